// File: rtl/mobo_bus_router.sv
// Routes one CPU ctrl/stat transaction at a time to one of NUM_DEV device channels,
// with four-phase handshakes on both sides and a per-phase timeout that raises ERR.
module mobo_bus_router #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_DEV    = 4,
    parameter int SEL_BITS   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_WIDTH-1:0]         cpu_ctrl,
    output logic [WORD_WIDTH-1:0]         cpu_stat,
    input  logic [WORD_WIDTH-1:0]         cpu_addr,
    input  logic [WORD_WIDTH-1:0]         cpu_wdata,
    output logic [WORD_WIDTH-1:0]         cpu_rdata,
    output logic [NUM_DEV*WORD_WIDTH-1:0] dev_ctrl,
    input  logic [NUM_DEV*WORD_WIDTH-1:0] dev_stat,
    output logic [WORD_WIDTH-1:0]         addr,
    output logic [WORD_WIDTH-1:0]         data_out,
    input  logic [NUM_DEV*WORD_WIDTH-1:0] data_in
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [WORD_WIDTH-1:0] ADDR_MASK =
        {{SEL_BITS{1'b0}}, {(WORD_WIDTH-SEL_BITS){1'b1}}};
    localparam logic [WORD_WIDTH-1:0] STAT_DONE = {{(WORD_WIDTH-2){1'b0}}, 2'b01};
    localparam logic [WORD_WIDTH-1:0] STAT_ERR  = {{(WORD_WIDTH-2){1'b0}}, 2'b11};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [SEL_BITS-1:0]   sel;
    logic [SEL_BITS-1:0]   req_sel;
    logic                  req_valid;
    logic                  sel_ack;
    logic [WORD_WIDTH-1:0] sel_rdata;
    logic                  unused_bits;

    assign req_sel     = cpu_addr[WORD_WIDTH-1 -: SEL_BITS];
    assign req_valid   = |cpu_ctrl[1:0];
    assign unused_bits = ^{cpu_ctrl, dev_stat};

    // Only the latched channel's ACK and read data are ever observed.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (int'(sel) == i) begin
                sel_ack   = dev_stat[i*WORD_WIDTH];
                sel_rdata = data_in[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sel       <= '0;
            cpu_stat  <= '0;
            cpu_rdata <= '0;
            dev_ctrl  <= '0;
            addr      <= '0;
            data_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cpu_stat <= '0;
                    if (req_valid) begin
                        sel      <= req_sel;
                        addr     <= cpu_addr & ADDR_MASK;
                        data_out <= cpu_wdata;
                        cnt      <= '0;
                        if (int'(req_sel) >= NUM_DEV) begin
                            state    <= S_ERR;
                            cpu_stat <= STAT_ERR;
                        end else begin
                            state <= S_REQ;
                            // READ wins over WRITE when both request bits are set.
                            for (int i = 0; i < NUM_DEV; i++) begin
                                if (int'(req_sel) == i) begin
                                    dev_ctrl[i*WORD_WIDTH +: WORD_WIDTH] <=
                                        {{(WORD_WIDTH-2){1'b0}}, cpu_ctrl[1], ~cpu_ctrl[1]};
                                end
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (sel_ack) begin
                        if (dev_ctrl[int'(sel)*WORD_WIDTH + 1]) begin
                            cpu_rdata <= sel_rdata;
                        end
                        dev_ctrl <= '0;
                        cnt      <= '0;
                        state    <= S_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        dev_ctrl <= '0;
                        cpu_stat <= STAT_ERR;
                        state    <= S_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (!sel_ack) begin
                        cpu_stat <= STAT_DONE;
                        state    <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        cpu_stat <= STAT_ERR;
                        state    <= S_ERR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (!req_valid) begin
                        cpu_stat <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    dev_ctrl <= '0;
                    cpu_stat <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mobo_bus_router.md
Name: mobo_bus_router

Overview:
- Parametrised successor to the motherboard bus controller.
- Routes one CPU ctrl/stat transaction at a time to one of NUM_DEV device channels, selected from the upper address bits.
- Uses a four-phase handshake on both the CPU side and the device side.
- Adds a per-transaction timeout and an explicit error status; a misbehaving device can no longer hang the CPU.

Parameters:
- WORD_WIDTH, 32: width of address, data, ctrl and stat words.
- NUM_DEV, 4: number of device channels, 1..2**SEL_BITS.
- SEL_BITS, 4: number of cpu_addr MSBs used as the device index.
- TIMEOUT, 255: device-handshake cycles allowed before an error is flagged; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_ctrl  in  WORD_WIDTH  bit0 = WRITE, bit1 = READ; other bits ignored; 0 = no request.
- cpu_stat  out  WORD_WIDTH  bit0 = DONE, bit1 = ERR; other bits 0.
- cpu_addr  in  WORD_WIDTH  CPU address.
- cpu_wdata  in  WORD_WIDTH  CPU write data.
- cpu_rdata  out  WORD_WIDTH  read data returned to the CPU.
- dev_ctrl  out  NUM_DEV*WORD_WIDTH  per-channel ctrl; slice i is [i*W +: W]; bit0 = WRITE, bit1 = READ.
- dev_stat  in  NUM_DEV*WORD_WIDTH  per-channel stat; bit0 = ACK.
- addr  out  WORD_WIDTH  shared device address = cpu_addr with the SEL_BITS MSBs cleared.
- data_out  out  WORD_WIDTH  shared device write data.
- data_in  in  NUM_DEV*WORD_WIDTH  per-channel device read data.

Behaviour:
- All outputs are registered.
- rst low (asynchronous) forces:
  - state = IDLE
  - cpu_stat, cpu_rdata, dev_ctrl, addr, data_out and the timeout counter = 0
- States: IDLE, REQ, RELEASE, DONE, ERR.
- IDLE:
  - cpu_stat = 0.
  - On the first edge with cpu_ctrl[1:0] != 0:
    - latch op, sel = cpu_addr[W-1 -: SEL_BITS], addr and data_out.
    - op is READ if bit1 = 1, otherwise WRITE; READ wins when both bits are set.
  - If sel >= NUM_DEV: go to ERR; no dev_ctrl slice is touched.
  - Otherwise: go to REQ with dev_ctrl[sel] = op and the counter cleared.
  - Latency: dev_ctrl is visible 1 cycle after cpu_ctrl is first sampled.
- REQ:
  - Counter increments every cycle.
  - On dev_stat[sel] bit0 = 1:
    - if op is READ, capture cpu_rdata = data_in[sel].
    - clear dev_ctrl[sel] and the counter; go to RELEASE.
  - Else, when the counter reaches TIMEOUT: clear dev_ctrl[sel] and go to ERR.
  - ACK takes priority over timeout on the same edge.
- RELEASE:
  - Waits for dev_stat[sel] bit0 = 0, then goes to DONE with cpu_stat = 01.
  - If ACK stays high for TIMEOUT cycles: go to ERR instead.
- DONE:
  - cpu_stat = 01 is held while cpu_ctrl != 0.
  - When cpu_ctrl == 0: cpu_stat = 0 and go to IDLE.
  - A new request is accepted no earlier than the cycle after IDLE is re-entered.
- ERR:
  - cpu_stat = 11 (DONE|ERR); cpu_rdata is unchanged.
  - When cpu_ctrl == 0: cpu_stat = 0 and go to IDLE.
- Invariants:
  - At most one dev_ctrl slice is nonzero at any time.
  - Non-selected slices are always 0.
- Bus hold:
  - addr and data_out keep their latched values until the next accepted request.
  - cpu_wdata and cpu_addr changes during a transaction are ignored.
- Device inputs:
  - ACK on a non-selected channel is ignored.
  - ACK already high on entry to REQ completes the transaction in 1 cycle.
- cpu_ctrl dropped mid-transaction: the device handshake still completes; DONE/ERR then exits to IDLE on the next edge.
- rst asserted mid-transaction: all dev_ctrl drop immediately (asynchronously); no partial status is left behind.
- Counter width: clog2(TIMEOUT+1) bits, with no wrap-around before the TIMEOUT compare.

Test Plan:
- Write to channel 1:
  - Stimulus: W=32, SEL_BITS=4; cpu_addr=0x1000_0040, cpu_wdata=0xDEAD_BEEF, cpu_ctrl=1; device acks 3 cycles later, then drops ACK.
  - Required: dev_ctrl[1]=1 one cycle after request; addr=0x0000_0040, data_out=0xDEAD_BEEF; cpu_stat=1 after the ACK falls; cpu_stat=0 one cycle after cpu_ctrl=0.
- Read from channel 2:
  - Stimulus: cpu_addr=0x2000_0008, cpu_ctrl=3, data_in[2]=0x1234_5678.
  - Required: dev_ctrl[2]=2 (READ wins); cpu_rdata=0x1234_5678 together with cpu_stat=1.
- Invalid device index:
  - Stimulus: NUM_DEV=4, cpu_addr=0x9000_0000, cpu_ctrl=2.
  - Required: all dev_ctrl remain 0; cpu_stat=3 on the next cycle.
- Timeout:
  - Stimulus: TIMEOUT=8; device 0 never acks.
  - Required: dev_ctrl[0] clears and cpu_stat=3 exactly 8 cycles after REQ is entered. A second run acking at cycle 8 must yield cpu_stat=1 (ACK priority).
- Stuck ACK:
  - Stimulus: ACK held high after the handshake.
  - Required: RELEASE times out and cpu_stat=3.
- Reset mid-REQ:
  - Stimulus: assert rst low during REQ.
  - Required: dev_ctrl, cpu_stat and addr read 0 immediately, without waiting for a clock; the next request after release behaves normally; a stray ACK on a non-selected channel is ignored.
